// File: rtl/exc_pkg.sv
// Shared types and constants for exception sequencing.
// Exception codes and default entry/reset addresses.
package exc_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;

endpackage

// File: rtl/hwint_sync.sv
// Multi-flop synchroniser chain for raw interrupt lines.
// Level passthrough with DEPTH cycles of latency.
module hwint_sync #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < DEPTH; i++)
            chain[i] <= chain[i-1];
      end
   end

   assign q = chain[DEPTH-1];

endmodule

// File: rtl/exc_sequencer.sv
// Exception entry / ERET sequencer between M stage and CP0.
// Drives flush and PC redirect; holds the resume PC across bubbles.
module exc_sequencer
   import exc_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int          HWINT_SYNC = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        m_valid_i,
   input  logic [31:0] m_pc_i,
   input  logic        m_bd_i,
   input  logic [4:0]  m_exccode_i,
   input  logic        m_eret_i,
   input  logic [5:0]  hwint_i,
   input  logic        cp0_req_i,
   input  logic [31:0] cp0_epc_i,
   output logic [31:0] cp0_vpc_o,
   output logic        cp0_bd_o,
   output logic [4:0]  cp0_exccode_o,
   output logic        cp0_exlclr_o,
   output logic [5:0]  cp0_hwint_o,
   output logic        flush_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic        busy_o
);

   state_t      state;
   logic [31:0] resume_pc_q;
   logic [5:0]  hwint_q;
   logic        hold;
   logic        exc_take;
   logic        eret_take;

   assign hold      = (state == HOLD);
   assign exc_take  = cp0_req_i;
   assign eret_take = ~hold & m_valid_i & m_eret_i
                    & ~stall_i & ~cp0_req_i;

   generate
      if (HWINT_SYNC == 0) begin : g_bypass
         assign hwint_q = hwint_i;
      end else begin : g_sync
         hwint_sync #(
            .DEPTH (HWINT_SYNC),
            .WIDTH (6)
         ) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (hwint_i),
            .q     (hwint_q)
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         resume_pc_q <= RESET_PC;
      end else if (exc_take) begin
         state       <= HOLD;
         resume_pc_q <= HANDLER_PC;
      end else if (eret_take) begin
         state       <= HOLD;
         resume_pc_q <= cp0_epc_i;
      end else if (hold && m_valid_i && !stall_i) begin
         state <= RUN;
      end
   end

   // Outputs are forced low for the whole time reset is held.
   always_comb begin
      cp0_vpc_o     = '0;
      cp0_bd_o      = 1'b0;
      cp0_exccode_o = EXC_INT;
      cp0_exlclr_o  = 1'b0;
      cp0_hwint_o   = '0;
      flush_o       = 1'b0;
      redirect_o    = 1'b0;
      redirect_pc_o = '0;
      busy_o        = 1'b0;
      if (!reset) begin
         cp0_hwint_o  = hwint_q;
         busy_o       = hold;
         cp0_exlclr_o = eret_take;
         flush_o      = exc_take | eret_take;
         redirect_o   = exc_take | eret_take;
         if (hold) begin
            cp0_vpc_o = resume_pc_q;
         end else begin
            cp0_vpc_o = m_pc_i;
            cp0_bd_o  = m_bd_i;
            if (m_valid_i)
               cp0_exccode_o = m_exccode_i;
         end
         if (exc_take)
            redirect_pc_o = HANDLER_PC;
         else if (eret_take)
            redirect_pc_o = cp0_epc_i;
      end
   end

endmodule

// File: tb/tb_exc_sequencer.sv
// Randomised scoreboard bench for exc_sequencer.
// Expected responses are queued by the driver, checked at negedge.
module tb_exc_sequencer;

   localparam logic [31:0] HPC = 32'h0000_4180;
   localparam logic [31:0] RPC = 32'h0000_3000;

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        valid;
      logic [31:0] pc;
      logic        bd;
      logic [4:0]  code;
      logic        eret;
      logic [5:0]  hw;
      logic        req;
      logic [31:0] epc;
   } in_t;

   typedef struct packed {
      logic [31:0] vpc;
      logic        bd;
      logic [4:0]  code;
      logic        exlclr;
      logic [5:0]  hw;
      logic [5:0]  hw0;
      logic        flush;
      logic        redir;
      logic [31:0] rpc;
      logic        busy;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i, m_valid_i, m_bd_i;
   logic        m_eret_i, cp0_req_i;
   logic [31:0] m_pc_i, cp0_epc_i;
   logic [4:0]  m_exccode_i;
   logic [5:0]  hwint_i;

   logic [31:0] vpc, rpc, vpc0, rpc0;
   logic        bd, exlclr, flush, redir, busy;
   logic        bd0, exlclr0, flush0, redir0, busy0;
   logic [4:0]  code, code0;
   logic [5:0]  hw, hw0;

   always #5 clk = ~clk;

   exc_sequencer dut (
      .clk(clk), .reset(reset), .stall_i(stall_i),
      .m_valid_i(m_valid_i), .m_pc_i(m_pc_i),
      .m_bd_i(m_bd_i), .m_exccode_i(m_exccode_i),
      .m_eret_i(m_eret_i), .hwint_i(hwint_i),
      .cp0_req_i(cp0_req_i), .cp0_epc_i(cp0_epc_i),
      .cp0_vpc_o(vpc), .cp0_bd_o(bd),
      .cp0_exccode_o(code), .cp0_exlclr_o(exlclr),
      .cp0_hwint_o(hw), .flush_o(flush),
      .redirect_o(redir), .redirect_pc_o(rpc),
      .busy_o(busy)
   );

   exc_sequencer #(.HWINT_SYNC(0)) dut0 (
      .clk(clk), .reset(reset), .stall_i(stall_i),
      .m_valid_i(m_valid_i), .m_pc_i(m_pc_i),
      .m_bd_i(m_bd_i), .m_exccode_i(m_exccode_i),
      .m_eret_i(m_eret_i), .hwint_i(hwint_i),
      .cp0_req_i(cp0_req_i), .cp0_epc_i(cp0_epc_i),
      .cp0_vpc_o(vpc0), .cp0_bd_o(bd0),
      .cp0_exccode_o(code0), .cp0_exlclr_o(exlclr0),
      .cp0_hwint_o(hw0), .flush_o(flush0),
      .redirect_o(redir0), .redirect_pc_o(rpc0),
      .busy_o(busy0)
   );

   // Reference model: "in handler window" flag, resume target,
   // and a record of the last two sampled interrupt levels.
   bit          m_hold;
   logic [31:0] m_resume;
   logic [5:0]  hist [2];
   in_t         cur;
   exp_t        sbq [$];
   int          passed = 0;
   int          total  = 0;

   function automatic exp_t model_out(input in_t v);
      exp_t e;
      bit   ex, er;
      e = '0;
      if (v.rst) return e;
      ex = v.req;
      er = !m_hold && v.valid && v.eret && !v.stall && !v.req;
      e.vpc    = m_hold ? m_resume : v.pc;
      e.bd     = m_hold ? 1'b0 : v.bd;
      e.code   = (m_hold || !v.valid) ? 5'd0 : v.code;
      e.exlclr = er;
      e.flush  = ex || er;
      e.redir  = ex || er;
      e.rpc    = ex ? HPC : (er ? v.epc : 32'd0);
      e.busy   = m_hold;
      e.hw     = hist[1];
      e.hw0    = v.hw;
      return e;
   endfunction

   task automatic model_edge(input in_t v);
      bit er;
      if (v.rst) begin
         m_hold   = 0;
         m_resume = RPC;
         hist[0]  = '0;
         hist[1]  = '0;
         return;
      end
      er = !m_hold && v.valid && v.eret && !v.stall && !v.req;
      hist[1] = hist[0];
      hist[0] = v.hw;
      if (v.req) begin
         m_hold = 1; m_resume = HPC;
      end else if (er) begin
         m_hold = 1; m_resume = v.epc;
      end else if (m_hold && v.valid && !v.stall) begin
         m_hold = 0;
      end
   endtask

   task automatic apply(input in_t v);
      reset       = v.rst;
      stall_i     = v.stall;
      m_valid_i   = v.valid;
      m_pc_i      = v.pc;
      m_bd_i      = v.bd;
      m_exccode_i = v.code;
      m_eret_i    = v.eret;
      hwint_i     = v.hw;
      cp0_req_i   = v.req;
      cp0_epc_i   = v.epc;
   endtask

   task automatic cycle(input in_t v);
      @(posedge clk);
      model_edge(cur);
      #1;
      cur = v;
      apply(v);
      sbq.push_back(model_out(v));
   endtask

   task automatic drv(
      input logic rs, input logic st, input logic va,
      input logic [31:0] pc, input logic [4:0] cd,
      input logic er, input logic [5:0] h,
      input logic rq, input logic [31:0] ep);
      in_t v;
      v.rst = rs; v.stall = st; v.valid = va;
      v.pc = pc; v.bd = 1'b0; v.code = cd;
      v.eret = er; v.hw = h; v.req = rq; v.epc = ep;
      cycle(v);
   endtask

   task automatic chk(input string n,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s t=%0t got=%h want=%h",
                    n, $time, act, exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() != 0) begin
         e = sbq.pop_front();
         chk("vpc", vpc, e.vpc);
         chk("bd", {31'd0, bd}, {31'd0, e.bd});
         chk("exccode", {27'd0, code}, {27'd0, e.code});
         chk("exlclr", {31'd0, exlclr}, {31'd0, e.exlclr});
         chk("hwint", {26'd0, hw}, {26'd0, e.hw});
         chk("flush", {31'd0, flush}, {31'd0, e.flush});
         chk("redirect", {31'd0, redir}, {31'd0, e.redir});
         if (e.redir) chk("redirect_pc", rpc, e.rpc);
         chk("busy", {31'd0, busy}, {31'd0, e.busy});
         chk("hwint_nosync", {26'd0, hw0}, {26'd0, e.hw0});
         chk("flush_nosync", {31'd0, flush0},
             {31'd0, e.flush});
      end
   end

   initial begin
      in_t v;
      cur = '0;
      cur.rst = 1'b1;
      apply(cur);
      m_hold = 0; m_resume = RPC;
      hist[0] = '0; hist[1] = '0;
      drv(1, 0, 0, 32'h0, 0, 0, 6'h0, 0, 32'h0);
      drv(0, 0, 0, 32'h0, 0, 0, 6'h0, 0, 32'h0);
      // overflow at M, then bubbles while in HOLD
      drv(0, 0, 1, 32'h3010, 12, 0, 6'h0, 1, 32'h0);
      drv(0, 0, 0, 32'hdead, 0, 0, 6'h0, 0, 32'h0);
      drv(0, 0, 1, 32'h4180, 0, 0, 6'h0, 0, 32'h0);
      drv(0, 0, 1, 32'h4184, 0, 1, 6'h0, 0, 32'h3020);
      drv(0, 0, 0, 32'hdead, 0, 0, 6'h0, 1, 32'h0);
      drv(0, 0, 1, 32'h4180, 0, 0, 6'h0, 0, 32'h0);
      // stalled ERET, then ERET racing a request
      drv(0, 1, 1, 32'h4188, 0, 1, 6'h0, 0, 32'h3024);
      drv(0, 1, 1, 32'h4188, 0, 1, 6'h0, 0, 32'h3024);
      drv(0, 1, 1, 32'h4188, 0, 1, 6'h0, 0, 32'h3024);
      drv(0, 0, 1, 32'h4188, 0, 1, 6'h0, 0, 32'h3024);
      drv(0, 0, 0, 32'h0, 0, 0, 6'h0, 0, 32'h0);
      drv(0, 0, 1, 32'h3024, 0, 0, 6'h0, 0, 32'h0);
      drv(0, 0, 1, 32'h3028, 0, 1, 6'h0, 1, 32'h3100);
      drv(0, 0, 1, 32'h4180, 0, 0, 6'h4, 0, 32'h0);
      drv(0, 0, 1, 32'h4184, 0, 0, 6'h4, 0, 32'h0);
      drv(0, 0, 1, 32'h4188, 0, 0, 6'h4, 0, 32'h0);
      // reset in HOLD
      drv(0, 0, 1, 32'h418c, 0, 0, 6'h4, 1, 32'h0);
      drv(1, 0, 1, 32'h1234, 0, 0, 6'h4, 1, 32'h0);
      drv(0, 0, 1, 32'h3000, 0, 0, 6'h4, 0, 32'h0);
      for (int i = 0; i < 3000; i++) begin
         v.rst   = ($urandom_range(0, 99) < 2);
         v.stall = ($urandom_range(0, 99) < 20);
         v.valid = ($urandom_range(0, 99) < 70);
         v.pc    = $urandom & 32'hffff_fffc;
         v.bd    = $urandom_range(0, 1);
         v.code  = ($urandom_range(0, 9) == 0) ?
                   5'($urandom_range(1, 31)) : 5'd0;
         v.eret  = ($urandom_range(0, 99) < 15);
         v.hw    = ($urandom_range(0, 7) == 0) ?
                   6'($urandom) : cur.hw;
         v.req   = ($urandom_range(0, 99) < 8);
         v.epc   = $urandom & 32'hffff_fffc;
         cycle(v);
      end
      @(negedge clk);
      #1;
      total++;
      if (sbq.size() == 0) passed++;
      else $display("FAIL drain got=%0d want=0", sbq.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
